// File: rtl/pri_pkg.sv
// Shared definitions for the 256-bit priority encoder/decoder pair:
// widths, decoder FSM states and a one-hot helper.
package pri_pkg;

  localparam int PRI_W  = 256;
  localparam int PRI_IW = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } pri_state_t;

  function automatic logic [PRI_W-1:0] onehot(input logic [PRI_IW-1:0] idx);
    logic [PRI_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pri_onehot_dec.sv
// Combinational index -> one-hot decoder; in_range is low for indices
// at or beyond W, in which case no bit is driven.
module pri_onehot_dec
  import pri_pkg::*;
#(
  parameter int W  = PRI_W,
  parameter int IW = PRI_IW
) (
  input  logic [IW-1:0] idx,
  output logic [W-1:0]  onehot_vec,
  output logic          in_range
);

  // decode one index into a single set bit
  always_comb begin
    onehot_vec = '0;
    in_range   = 1'b0;
    if (32'(idx) < 32'(W)) begin
      in_range        = 1'b1;
      onehot_vec[idx] = 1'b1;
    end else begin
      in_range   = 1'b0;
      onehot_vec = '0;
    end
  end

endmodule

// File: rtl/pri_decoder256.sv
// Rebuilds a W-bit request vector from a stream of bit indices and holds
// the finished vector, its popcount and an error flag until consumed.
module pri_decoder256
  import pri_pkg::*;
#(
  parameter int W  = PRI_W,
  parameter int IW = PRI_IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_idx,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_vec,
  output logic [IW:0]   out_count,
  output logic          out_err
);

  pri_state_t    state_r, state_nxt_s;
  logic [W-1:0]  acc_r, acc_nxt_s;
  logic [IW:0]   cnt_r, cnt_nxt_s;
  logic          err_r, err_nxt_s;
  logic [W-1:0]  out_vec_r;
  logic [IW:0]   out_count_r;
  logic          out_err_r;
  logic [W-1:0]  dec_vec_s;
  logic          dec_ok_s;
  logic          beat_s;
  logic          dup_s;
  logic          in_ready_s;
  logic          out_valid_s;

  pri_onehot_dec #(.W(W), .IW(IW)) u_dec (
    .idx        (in_idx),
    .onehot_vec (dec_vec_s),
    .in_range   (dec_ok_s)
  );

  assign beat_s = in_valid && in_ready_s;
  assign dup_s  = |(acc_r & dec_vec_s);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (beat_s) begin
          state_nxt_s = in_last ? ST_HOLD : ST_COLLECT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (beat_s && in_last) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_COLLECT;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake flags depend on state only
  always_comb begin
    in_ready_s  = 1'b1;
    out_valid_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_COLLECT: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
      ST_HOLD: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Accumulator update for one beat; duplicates and out-of-range set the flag
  always_comb begin
    acc_nxt_s = acc_r;
    cnt_nxt_s = cnt_r;
    err_nxt_s = err_r;
    if (beat_s) begin
      if (!dec_ok_s || dup_s) begin
        err_nxt_s = 1'b1;
      end else begin
        acc_nxt_s = acc_r | dec_vec_s;
        cnt_nxt_s = cnt_r + (IW+1)'(1);
      end
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // Accumulator, counter, error flag and the presented result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r       <= '0;
      cnt_r       <= '0;
      err_r       <= 1'b0;
      out_vec_r   <= '0;
      out_count_r <= '0;
      out_err_r   <= 1'b0;
    end else if (state_r == ST_HOLD) begin
      if (out_ready) begin
        acc_r       <= '0;
        cnt_r       <= '0;
        err_r       <= 1'b0;
        out_vec_r   <= '0;
        out_count_r <= '0;
        out_err_r   <= 1'b0;
      end
    end else begin
      acc_r <= acc_nxt_s;
      cnt_r <= cnt_nxt_s;
      err_r <= err_nxt_s;
      if (beat_s && in_last) begin
        out_vec_r   <= acc_nxt_s;
        out_count_r <= cnt_nxt_s;
        out_err_r   <= err_nxt_s;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_vec   = out_vec_r;
  assign out_count = out_count_r;
  assign out_err   = out_err_r;

endmodule

// File: tb/tb_pri_decoder256.sv
// Bench for pri_decoder256: directed frames with literal expectations plus a
// randomized phase, all checked every cycle against a set-based frame model.
module tb_pri_decoder256;

  localparam int W  = 256;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_idx;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_vec;
  logic [IW:0]   out_count;
  logic          out_err;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  pri_decoder256 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_count (out_count),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk_vec(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chk_num(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  // Frame model: the set of indices seen in the current frame, the result
  // captured when a frame closes, and whether that result is being held.
  logic [W-1:0] m_acc  = '0;
  logic [W-1:0] m_out  = '0;
  bit           m_err  = 1'b0;
  bit           m_oerr = 1'b0;
  bit           m_hold = 1'b0;
  int           m_ocnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc = '0; m_out = '0; m_err = 1'b0; m_oerr = 1'b0; m_hold = 1'b0; m_ocnt = 0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 1'b0; m_out = '0; m_oerr = 1'b0; m_ocnt = 0;
      end
    end else if (in_valid) begin
      if (int'(in_idx) >= W) m_err = 1'b1;
      else if (m_acc[in_idx]) m_err = 1'b1;
      else m_acc[in_idx] = 1'b1;
      if (in_last) begin
        m_out  = m_acc;
        m_ocnt = $countones(m_acc);
        m_oerr = m_err;
        m_hold = 1'b1;
        m_acc  = '0;
        m_err  = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk_num("cyc_in_ready", int'(in_ready), int'(!m_hold));
      chk_num("cyc_out_valid", int'(out_valid), int'(m_hold));
      chk_vec("cyc_out_vec", out_vec, m_out);
      chk_num("cyc_out_count", int'(out_count), m_ocnt);
      chk_num("cyc_out_err", int'(out_err), int'(m_oerr));
    end
  end

  // Present one beat from a negedge; returns at the negedge after acceptance
  task automatic beat(input int idx, input bit last);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_idx   = IW'(idx);
    in_last  = last;
    n        = 0;
    do begin
      acc = in_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      n_chk++;
      $display("FAIL beat_timeout: idx %0d not accepted within %0d cycles", idx, n);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk_num("release_valid", int'(out_valid), 0);
    chk_num("release_ready", int'(in_ready), 1);
  endtask

  logic [W-1:0] e;
  bit prev_v, prev_r;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_idx = '0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    chk_num("rst_in_ready", int'(in_ready), 1);
    chk_num("rst_out_valid", int'(out_valid), 0);
    e = '0;
    chk_vec("rst_out_vec", out_vec, e);
    #2 rst = 1'b0;
    @(negedge clk);

    // single-beat frames at both ends
    beat(0, 1'b1);
    e = 256'h1;
    chk_num("s0_valid", int'(out_valid), 1);
    chk_vec("s0_vec", out_vec, e);
    chk_num("s0_count", int'(out_count), 1);
    chk_num("s0_err", int'(out_err), 0);
    release_out();
    beat(255, 1'b1);
    e = '0; e[255] = 1'b1;
    chk_vec("s255_vec", out_vec, e);
    chk_num("s255_count", int'(out_count), 1);
    release_out();

    // multi-beat frame
    beat(200, 1'b0); beat(100, 1'b0); beat(3, 1'b1);
    e = '0; e[200] = 1'b1; e[100] = 1'b1; e[3] = 1'b1;
    chk_vec("multi_vec", out_vec, e);
    chk_num("multi_count", int'(out_count), 3);
    chk_num("multi_err", int'(out_err), 0);
    chk_num("multi_ready", int'(in_ready), 0);

    // backpressure with a stalled beat waiting
    in_valid = 1'b1; in_idx = 8'd50; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_vec("bp_vec_stable", out_vec, e);
      chk_num("bp_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk_num("bp_valid_drop", int'(out_valid), 0);
    chk_num("bp_ready_rise", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    e = '0; e[50] = 1'b1;
    chk_vec("bp_next_vec", out_vec, e);
    chk_num("bp_next_count", int'(out_count), 1);
    chk_num("bp_next_err", int'(out_err), 0);
    release_out();

    // duplicate index
    beat(7, 1'b0); beat(7, 1'b0); beat(9, 1'b1);
    e = '0; e[7] = 1'b1; e[9] = 1'b1;
    chk_vec("dup_vec", out_vec, e);
    chk_num("dup_count", int'(out_count), 2);
    chk_num("dup_err", int'(out_err), 1);
    release_out();
    beat(5, 1'b1);
    chk_num("post_dup_err", int'(out_err), 0);
    release_out();

    // reset in the middle of a frame
    beat(10, 1'b0); beat(11, 1'b0);
    #2 rst = 1'b1;
    #1;
    e = '0;
    chk_num("midrst_valid", int'(out_valid), 0);
    chk_vec("midrst_vec", out_vec, e);
    chk_num("midrst_count", int'(out_count), 0);
    chk_num("midrst_err", int'(out_err), 0);
    chk_num("midrst_ready", int'(in_ready), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    beat(12, 1'b1);
    e = '0; e[12] = 1'b1;
    chk_vec("midrst_next_vec", out_vec, e);
    chk_num("midrst_next_count", int'(out_count), 1);
    release_out();

    // round trip of the encoder's index stream
    beat(63, 1'b0); beat(62, 1'b0); beat(61, 1'b0); beat(60, 1'b0); beat(0, 1'b1);
    e = 256'hF000_0000_0000_0001;
    chk_vec("rt_vec", out_vec, e);
    chk_vec("rt_model", m_out, e);
    chk_num("rt_count", int'(out_count), 5);
    chk_num("rt_model_count", m_ocnt, 5);
    release_out();

    // randomized traffic; a stalled beat is held stable
    prev_v = 1'b0; prev_r = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (!(prev_v && !prev_r)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_idx   = ($urandom_range(0, 1) == 0) ? IW'($urandom_range(0, 15)) : IW'($urandom_range(0, 255));
        in_last  = ($urandom_range(0, 5) == 0);
      end
      out_ready = ($urandom_range(0, 2) == 0);
      prev_v = in_valid;
      prev_r = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
